multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencing controller for the multi-cycle variant of our MIPS datapath. Decodes op_in/func_in from
//  the instruction register and walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, one step per clock.
//  Drives the shared-ALU/shared-memory datapath muxes and write strobes. Stalls on a memory ready handshake.
//  Supports the same ISA subset and ALUCntrl codes as the single-cycle decoder.
// PARAMETERS
//  CNT_WIDTH   32  width of the optional performance counters
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  op_in        in   6   IR[31:26]; stable from the cycle after the FETCH commit
//  func_in      in   6   IR[5:0]
//  mem_ready    in   1   memory completes the current access this cycle
//  zero_in      in   1   ALU zero flag (for BEQ)
//  pcWrite      out  1   unconditional PC load
//  pcWriteCond  out  1   PC load if zero_in (the datapath ANDs the two)
//  iorD         out  1   0 = memory address from PC, 1 = from ALUOut
//  memRead      out  1   memory read request
//  memWrite     out  1   memory write request
//  irWrite      out  1   IR load
//  memToReg     out  1   0 = ALUOut, 1 = MDR to the register file
//  regDst       out  1   0 = rt, 1 = rd
//  regWrite     out  1   register file write
//  ALUSrcA      out  1   0 = PC, 1 = regA
//  ALUSrcB      out  2   00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  ALUCntrl     out  4   0000 ADD, 0001 SUB, 0010 AND, 0100 SLT, 0101 OR, 1000 MEM/CMP, 1111 NOP
//  PCSource     out  2   00 = ALU result, 01 = ALUOut, 10 = jump target
//  illegal      out  1   sticky: an unsupported opcode/funct was decoded
//  state_out    out  4   current state, for debug
// BEHAVIOUR
//  Reset (async, any time, including mid-access): state = FETCH, illegal = 0, counters = 0.
//   While rst_n = 0, every strobe is 0, ALUCntrl = 1111, and all selects are 0.
//  Outputs are a decode of the state register (Moore). Exception: pcWrite and irWrite in FETCH are
//   gated by mem_ready.
//  FETCH: memRead = 1, iorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUCntrl = ADD, PCSource = 00.
//   Stay in FETCH while mem_ready = 0. On mem_ready = 1, assert irWrite and pcWrite and go to DECODE.
//  DECODE: ALUSrcA = 0, ALUSrcB = 11, ADD (branch target into ALUOut). Next state by op/func:
//   R-type ADD/SUB/AND/SLT/OR -> EXEC_R; LW/SW (100011/101011) -> MEM_ADDR; ADDI (001000) -> EXEC_I;
//   BEQ (000100) -> BRANCH; J (000010) -> JUMP; op = 0 with func = 0 (NOP) -> FETCH;
//   anything else -> ILLEGAL.
//  EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUCntrl from func (codes above) -> WB_R.
//  WB_R: regDst = 1, memToReg = 0, regWrite = 1 -> FETCH.
//  EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ADD -> WB_I.  WB_I: regDst = 0, memToReg = 0, regWrite = 1 -> FETCH.
//  MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUCntrl = 1000 -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: memRead = 1, iorD = 1. Hold until mem_ready, then -> WB_MEM.
//  WB_MEM: regDst = 0, memToReg = 1, regWrite = 1 -> FETCH.
//  MEM_WR: memWrite = 1, iorD = 1. Hold until mem_ready, then -> FETCH.
//   memWrite stays asserted, with the address unchanged, for every stall cycle.
//  BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUCntrl = 1000, pcWriteCond = 1, PCSource = 01 -> FETCH.
//  JUMP: pcWrite = 1, PCSource = 10 -> FETCH.
//  ILLEGAL: all strobes 0, illegal = 1. Terminal state, left only by reset.
//  Cycle counts with no memory stall: NOP 2; BEQ/J 3; R-type/ADDI/SW 4; LW 5.
//   Each mem_ready = 0 cycle adds one cycle.
//  memRead and memWrite are never asserted in the same cycle. regWrite is asserted only in WB_*.
//  State encoding is 4 bits; unused encodings go to ILLEGAL.
// CONFIGURATION
//  MULTICYCLE_PERF_CNT_EN defined:
//   - Adds outputs cycle_cnt and instr_cnt [CNT_WIDTH-1:0].
//   - cycle_cnt increments every clock outside reset and ILLEGAL.
//   - instr_cnt increments on every transition into FETCH from a state other than FETCH.
//   - Both wrap modulo 2^CNT_WIDTH.
//  Undefined: no counter ports and no counter logic.
// STRUCTURE
//  Shared package mc_ctrl_pkg holds:
//   - state localparams (FETCH..ILLEGAL);
//   - opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, FN_ADD, ...);
//   - ALUCntrl codes (ALU_ADD = 0000, ALU_SUB, ALU_AND, ALU_SLT, ALU_OR, ALU_MEM = 1000, ALU_NOP = 1111);
//   - ALUSrcB and PCSource select codes.
//  Sub-module mc_perf_counters holds the two counters and is instantiated only under the macro.
// TESTING
//  1. Reset asserted mid-MEM_RD (mem_ready = 0) -> that same cycle state_out = FETCH, memRead = 0
//     while in reset, illegal = 0.
//  2. ADD (op 000000, func 100000), mem_ready = 1 -> 4 cycles; EXEC_R ALUCntrl = 0000;
//     WB_R has regWrite = 1 and regDst = 1.
//  3. LW with mem_ready low for 3 cycles in MEM_RD -> 8 cycles total, memRead held high,
//     and regWrite = 1 with memToReg = 1 exactly once.
//  4. SW with mem_ready low for 2 FETCH cycles -> irWrite and pcWrite stay 0 until mem_ready;
//     MEM_WR has memWrite = 1 and iorD = 1; 6 cycles total.
//  5. BEQ then J -> BRANCH has pcWriteCond = 1 and PCSource = 01;
//     JUMP has pcWrite = 1 and PCSource = 10; 3 cycles each.
//  6. op 111111 -> ILLEGAL; illegal = 1 and stays 1 over 10 clocks; no strobes; reset clears it.
//     With MULTICYCLE_PERF_CNT_EN: cycle_cnt frozen in ILLEGAL, and instr_cnt = 2 after NOP, NOP.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller:
// state codes, opcode/funct values, ALU codes, mux selects.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_WB_R     = 4'd3;
    localparam logic [3:0] ST_EXEC_I   = 4'd4;
    localparam logic [3:0] ST_WB_I     = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_RD   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_MEM_WR   = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_ILLEGAL  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_MEM = 4'b1000;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_cntrl;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        c.alu_cntrl = ALU_NOP;
        return c;
    endfunction

    // ALU_NOP doubles as "funct not supported".
    function automatic logic [3:0] alu_from_func(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR fields, memory handshake,
// zero flag in; mux selects and write strobes out.
interface multicycle_control_fsm_if;

    logic [5:0] op_in;
    logic [5:0] func_in;
    logic       mem_ready;
    logic       zero_in;

    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUCntrl;
    logic [1:0] PCSource;
    logic       illegal;
    logic [3:0] state_out;

    modport master (
        input  op_in, func_in, mem_ready, zero_in,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite,
        output irWrite, memToReg, regDst, regWrite,
        output ALUSrcA, ALUSrcB, ALUCntrl, PCSource,
        output illegal, state_out
    );

    modport slave (
        output op_in, func_in, mem_ready, zero_in,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite,
        input  irWrite, memToReg, regDst, regWrite,
        input  ALUSrcA, ALUSrcB, ALUCntrl, PCSource,
        input  illegal, state_out
    );

endinterface

// File: rtl/multicycle_control_fsm_perf_counters.sv
// Performance counters: cycles outside reset/ILLEGAL and retired
// instructions (entries into FETCH). Ports: clk, rst_n, state, state_nx, counts.
module mc_perf_counters
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           state,
    input  logic [3:0]           state_nx,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    logic retire;

    assign retire = (state_nx == ST_FETCH) && (state != ST_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != ST_ILLEGAL)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller (Moore decode, mem_ready stalls).
// Ports: clk, rst_n, bus (master); MULTICYCLE_PERF_CNT_EN adds cycle_cnt/instr_cnt.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master bus
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     cycle_cnt,
    output logic [CNT_WIDTH-1:0]     instr_cnt
`endif
);

    logic [3:0] state;
    logic [3:0] state_nx;
    ctrl_t      c;

    logic is_nop;
    logic is_r;
    logic is_mem;

    assign is_nop = (bus.op_in == OP_RTYPE) && (bus.func_in == FN_NOP);
    assign is_r   = (bus.op_in == OP_RTYPE)
                 && (alu_from_func(bus.func_in) != ALU_NOP);
    assign is_mem = (bus.op_in == OP_LW) || (bus.op_in == OP_SW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_FETCH;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH:
                if (bus.mem_ready)
                    state_nx = ST_DECODE;
            ST_DECODE: begin
                unique case (1'b1)
                    is_nop:                   state_nx = ST_FETCH;
                    is_r:                     state_nx = ST_EXEC_R;
                    is_mem:                   state_nx = ST_MEM_ADDR;
                    (bus.op_in == OP_ADDI):   state_nx = ST_EXEC_I;
                    (bus.op_in == OP_BEQ):    state_nx = ST_BRANCH;
                    (bus.op_in == OP_J):      state_nx = ST_JUMP;
                    default:                  state_nx = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R:   state_nx = ST_WB_R;
            ST_WB_R:     state_nx = ST_FETCH;
            ST_EXEC_I:   state_nx = ST_WB_I;
            ST_WB_I:     state_nx = ST_FETCH;
            ST_MEM_ADDR: begin
                unique case (1'b1)
                    (bus.op_in == OP_LW): state_nx = ST_MEM_RD;
                    (bus.op_in == OP_SW): state_nx = ST_MEM_WR;
                    default:              state_nx = ST_ILLEGAL;
                endcase
            end
            ST_MEM_RD:
                if (bus.mem_ready)
                    state_nx = ST_WB_MEM;
            ST_WB_MEM:   state_nx = ST_FETCH;
            ST_MEM_WR:
                if (bus.mem_ready)
                    state_nx = ST_FETCH;
            ST_BRANCH:   state_nx = ST_FETCH;
            ST_JUMP:     state_nx = ST_FETCH;
            ST_ILLEGAL:  state_nx = ST_ILLEGAL;
            default:     state_nx = ST_ILLEGAL;
        endcase
    end

    always_comb begin
        c = ctrl_idle();
        case (state)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_cntrl = ALU_ADD;
                c.pc_source = PC_ALU;
                // only commit the fetch once memory delivers
                c.ir_write  = bus.mem_ready;
                c.pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_cntrl = ALU_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_cntrl = alu_from_func(bus.func_in);
            end
            ST_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_cntrl = ALU_ADD;
            end
            ST_WB_I: begin
                c.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_cntrl = ALU_MEM;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            ST_WB_MEM: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_cntrl     = ALU_MEM;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_JUMP;
            end
            default: ;
        endcase
        // state is already FETCH in reset; this silences FETCH's strobes
        if (!rst_n)
            c = ctrl_idle();
    end

    assign bus.pcWrite     = c.pc_write;
    assign bus.pcWriteCond = c.pc_write_cond;
    assign bus.iorD        = c.ior_d;
    assign bus.memRead     = c.mem_read;
    assign bus.memWrite    = c.mem_write;
    assign bus.irWrite     = c.ir_write;
    assign bus.memToReg    = c.mem_to_reg;
    assign bus.regDst      = c.reg_dst;
    assign bus.regWrite    = c.reg_write;
    assign bus.ALUSrcA     = c.alu_src_a;
    assign bus.ALUSrcB     = c.alu_src_b;
    assign bus.ALUCntrl    = c.alu_cntrl;
    assign bus.PCSource    = c.pc_source;
    assign bus.illegal     = rst_n && (state == ST_ILLEGAL);
    assign bus.state_out   = state;

`ifdef MULTICYCLE_PERF_CNT_EN
    mc_perf_counters #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .state_nx  (state_nx),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`endif

endmodule
